packet_word_packer: RTL and testbench

PACKET_WORD_PACKER -- requirements
Module: packet_word_packer

---
 rtl/packet_word_packer_if.sv | 28 ++
 rtl/packet_word_packer.sv | 120 ++++++++++++
 tb/tb_packet_word_packer.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/packet_word_packer_if.sv
// Byte-stream in / packed-word FIFO out bundle for packet_word_packer.
// The packer sits on the slave modport; the producer/FIFO side uses master.
interface packet_word_packer_if #(
   parameter int WORD_WIDTH = 64,
   parameter int LEN_WIDTH  = 16
);
   logic                  s_valid_i;
   logic [7:0]            s_data_i;
   logic                  s_last_i;
   logic                  s_ready_o;
   logic                  fifo_full_i;
   logic                  fifo_write_en_o;
   logic [WORD_WIDTH-1:0] fifo_data_o;
   logic [LEN_WIDTH-1:0]  pkt_len_o;
   logic                  pkt_len_valid_o;

   modport master (
      output s_valid_i, s_data_i, s_last_i, fifo_full_i,
      input  s_ready_o, fifo_write_en_o, fifo_data_o,
      input  pkt_len_o, pkt_len_valid_o
   );

   modport slave (
      input  s_valid_i, s_data_i, s_last_i, fifo_full_i,
      output s_ready_o, fifo_write_en_o, fifo_data_o,
      output pkt_len_o, pkt_len_valid_o
   );
endinterface

// File: rtl/packet_word_packer.sv
// Packs a byte stream into little-endian lane words for a packet FIFO.
// Define PKT_LEN_COUNT_EN to add the saturating per-packet length report.
module packet_word_packer #(
   parameter int WORD_WIDTH = 64,
   parameter int LEN_WIDTH  = 16
) (
   input logic                 clk_i,
   input logic                 rst_i,
   packet_word_packer_if.slave bus
);
   localparam int LANES = WORD_WIDTH / 8;
   localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

   typedef enum logic [1:0] {IDLE, FILL, STALL} state_e;

   state_e                state_q, state_d, ret_q, ret_d, base;
   logic [WORD_WIDTH-1:0] asm_q, asm_d, word_q, word_d, ins;
   logic [LW-1:0]         lane_q, lane_d;
   logic                  wvalid_q, wvalid_d;
   logic                  ready, accept, complete, write;

   assign ready    = !rst_i && (!wvalid_q || !bus.fifo_full_i);
   assign accept   = bus.s_valid_i && ready;
   assign complete = accept && (bus.s_last_i || lane_q == LW'(LANES - 1));
   assign write    = !rst_i && wvalid_q && !bus.fifo_full_i;
   assign ins      = WORD_WIDTH'(bus.s_data_i) << {lane_q, 3'b000};

   // Assembly clears on completion, so unfilled lanes of a short word are zero
   always_comb begin
      asm_d    = asm_q;
      lane_d   = lane_q;
      word_d   = word_q;
      wvalid_d = wvalid_q;
      if (write) wvalid_d = 1'b0;
      if (accept) begin
         if (complete) begin
            word_d   = asm_q | ins;
            wvalid_d = 1'b1;
            asm_d    = '0;
            lane_d   = '0;
         end else begin
            asm_d  = asm_q | ins;
            lane_d = lane_q + 1'b1;
         end
      end
   end

   always_comb begin
      base    = (state_q == STALL) ? ret_q : state_q;
      state_d = base;
      ret_d   = ret_q;
      if (accept) state_d = bus.s_last_i ? IDLE : FILL;
      if (wvalid_q && bus.fifo_full_i) begin
         state_d = STALL;
         ret_d   = base;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         ret_q    <= IDLE;
         asm_q    <= '0;
         word_q   <= '0;
         lane_q   <= '0;
         wvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ret_q    <= ret_d;
         asm_q    <= asm_d;
         word_q   <= word_d;
         lane_q   <= lane_d;
         wvalid_q <= wvalid_d;
      end
   end

   assign bus.s_ready_o       = ready;
   assign bus.fifo_write_en_o = write;
   assign bus.fifo_data_o     = rst_i ? '0 : word_q;

`ifdef PKT_LEN_COUNT_EN
   logic [LEN_WIDTH-1:0] cnt_q, cnt_d, len_q, len_d, cnt_inc;
   logic                 lenv_q, lenv_d;

   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      cnt_d  = cnt_q;
      len_d  = len_q;
      lenv_d = 1'b0;
      if (accept) begin
         if (bus.s_last_i) begin
            len_d  = cnt_inc;
            lenv_d = 1'b1;
            cnt_d  = '0;
         end else begin
            cnt_d = cnt_inc;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         len_q  <= '0;
         lenv_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         len_q  <= len_d;
         lenv_q <= lenv_d;
      end
   end

   assign bus.pkt_len_o       = rst_i ? '0 : len_q;
   assign bus.pkt_len_valid_o = !rst_i && lenv_q;
`else
   assign bus.pkt_len_o       = LEN_WIDTH'(0);
   assign bus.pkt_len_valid_o = 1'b0;
`endif
endmodule

// File: tb/tb_packet_word_packer.sv
// Randomised bench for packet_word_packer against a packet-level model.
// Length checks expect zero outputs unless PKT_LEN_COUNT_EN is defined.
module tb_packet_word_packer;
   localparam int WW = 64;
   localparam int LW = 16;
`ifdef PKT_LEN_COUNT_EN
   localparam bit LEN_ON = 1'b1;
`else
   localparam bit LEN_ON = 1'b0;
`endif

   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   packet_word_packer_if #(.WORD_WIDTH(WW), .LEN_WIDTH(LW)) bus();

   packet_word_packer #(.WORD_WIDTH(WW), .LEN_WIDTH(LW)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic          full_man  = 1'b0;
   logic          rnd_full  = 1'b0;
   bit            rnd_mode  = 1'b0;
   assign bus.fifo_full_i = rnd_mode ? rnd_full : full_man;

   logic [WW-1:0] wr_q[$];
   int            wr_cyc[$];
   int            len_q[$];
   int            acc_cyc[$];
   logic [WW-1:0] exp_w[$];
   int            exp_len[$];

   always @(posedge clk) begin
      cyc++;
      #1 rnd_full = ($urandom_range(0, 3) == 0);
   end

   always @(negedge clk) begin
      if (bus.fifo_write_en_o === 1'b1) begin
         wr_q.push_back(bus.fifo_data_o);
         wr_cyc.push_back(cyc);
      end
      if (bus.pkt_len_valid_o === 1'b1) len_q.push_back(int'(bus.pkt_len_o));
      if (bus.s_valid_i && bus.s_ready_o === 1'b1) acc_cyc.push_back(cyc);
   end

   // Packet-level model: 8-byte chunks, byte k of a chunk in lane k
   function automatic void model_pkt(input bq_t p);
      logic [WW-1:0] w;
      for (int i = 0; i < p.size(); i += WW / 8) begin
         w = '0;
         for (int k = 0; k < WW / 8 && i + k < p.size(); k++)
            w[8*k +: 8] = p[i+k];
         exp_w.push_back(w);
      end
      exp_len.push_back(p.size() > 65535 ? 65535 : p.size());
   endfunction

   task automatic clear_log();
      wr_q.delete();
      wr_cyc.delete();
      len_q.delete();
      acc_cyc.delete();
      exp_w.delete();
      exp_len.delete();
   endtask

   task automatic idle(input int n);
      bus.s_valid_i = 1'b0;
      bus.s_last_i  = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic put_byte(input logic [7:0] d, input logic last,
                           input int gap);
      int n;
      bit acc;
      if (gap > 0 && $urandom_range(0, 99) < gap) begin
         bus.s_valid_i = 1'b0;
         @(posedge clk);
         #1;
      end
      bus.s_valid_i = 1'b1;
      bus.s_data_i  = d;
      bus.s_last_i  = last;
      n   = 0;
      acc = 1'b0;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = (bus.s_ready_o === 1'b1);
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: byte %h not accepted in %0d cycles",
                  d, n);
      end
   endtask

   task automatic send_pkt(input bq_t p, input int gap);
      for (int i = 0; i < p.size(); i++)
         put_byte(p[i], i == p.size() - 1, gap);
      model_pkt(p);
   endtask

   task automatic test_reset();
      logic [WW-1:0] got;
      rst           = 1'b1;
      bus.s_valid_i = 1'b1;
      bus.s_data_i  = 8'hFF;
      bus.s_last_i  = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      n_checks++;
      if (bus.s_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_ready: got %b want 0", bus.s_ready_o);
      end
      n_checks++;
      if (bus.fifo_write_en_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_wen: got %b want 0", bus.fifo_write_en_o);
      end
      n_checks++;
      if (bus.fifo_data_o !== '0) begin
         n_fail++;
         $display("FAIL rst_data: got %h want 0", bus.fifo_data_o);
      end
      n_checks++;
      if (bus.pkt_len_o !== '0) begin
         n_fail++;
         $display("FAIL rst_len: got %h want 0", bus.pkt_len_o);
      end
      n_checks++;
      if (bus.pkt_len_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_lenv: got %b want 0", bus.pkt_len_valid_o);
      end
      @(posedge clk);
      #1;
      rst           = 1'b0;
      bus.s_valid_i = 1'b0;
      bus.s_last_i  = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.s_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL post_rst_ready: got %b want 1", bus.s_ready_o);
      end
      clear_log();
      idle(3);
      n_checks++;
      got = wr_q.size() > 0 ? wr_q[0] : '0;
      if (wr_q.size() != 0) begin
         n_fail++;
         $display("FAIL post_rst_writes: got %0d (%h) want 0",
                  wr_q.size(), got);
      end
   endtask

   task automatic test_full_word();
      bq_t p;
      logic [WW-1:0] got;
      int gl;
      clear_log();
      for (int i = 1; i <= 8; i++) p.push_back(8'(i));
      send_pkt(p, 0);
      idle(4);
      got = wr_q.size() > 0 ? wr_q[0] : 'x;
      gl  = len_q.size() > 0 ? len_q[0] : 0;
      n_checks++;
      if (wr_q.size() != 1) begin
         n_fail++;
         $display("FAIL full_count: got %0d want 1", wr_q.size());
      end
      n_checks++;
      if (got !== 64'h0807060504030201) begin
         n_fail++;
         $display("FAIL full_data: got %h want 0807060504030201", got);
      end
      n_checks++;
      if (len_q.size() != (LEN_ON ? 1 : 0) || gl != (LEN_ON ? 8 : 0)) begin
         n_fail++;
         $display("FAIL full_len: got %0d pulses len %0d want len %0d",
                  len_q.size(), gl, LEN_ON ? 8 : 0);
      end
      n_checks++;
      if (wr_cyc.size() < 1 || acc_cyc.size() < 8 ||
          wr_cyc[0] != acc_cyc[7] + 1) begin
         n_fail++;
         $display("FAIL full_latency: write cycle %0d accept cycle %0d",
                  wr_cyc.size() ? wr_cyc[0] : -1,
                  acc_cyc.size() > 7 ? acc_cyc[7] : -1);
      end
   endtask

   task automatic test_partial();
      bq_t p;
      logic [WW-1:0] got;
      int gl;
      clear_log();
      p = '{8'hAA, 8'hBB, 8'hCC};
      send_pkt(p, 0);
      idle(4);
      got = wr_q.size() > 0 ? wr_q[0] : 'x;
      gl  = len_q.size() > 0 ? len_q[0] : 0;
      n_checks++;
      if (wr_q.size() != 1 || got !== 64'h0000000000CCBBAA) begin
         n_fail++;
         $display("FAIL partial_data: got %0d writes %h want 1 x CCBBAA",
                  wr_q.size(), got);
      end
      n_checks++;
      if (gl != (LEN_ON ? 3 : 0)) begin
         n_fail++;
         $display("FAIL partial_len: got %0d want %0d", gl, LEN_ON ? 3 : 0);
      end
   endtask

   task automatic test_back_to_back();
      bq_t p1, p2;
      logic [WW-1:0] g0, g1;
      clear_log();
      p1 = '{8'h5A};
      for (int i = 0; i < 8; i++) p2.push_back(8'(8'h21 + i));
      send_pkt(p1, 0);
      send_pkt(p2, 0);
      idle(4);
      g0 = wr_q.size() > 0 ? wr_q[0] : 'x;
      g1 = wr_q.size() > 1 ? wr_q[1] : 'x;
      n_checks++;
      if (wr_q.size() != 2 || g0 !== 64'h5A) begin
         n_fail++;
         $display("FAIL b2b_first: got %0d writes first %h want 2, 5A",
                  wr_q.size(), g0);
      end
      n_checks++;
      if (g1 !== 64'h2827262524232221) begin
         n_fail++;
         $display("FAIL b2b_second: got %h want 2827262524232221", g1);
      end
      n_checks++;
      if (acc_cyc.size() != 9 || acc_cyc[8] - acc_cyc[0] != 8) begin
         n_fail++;
         $display("FAIL b2b_bubble: %0d accepts spanning %0d cycles want 9/8",
                  acc_cyc.size(),
                  acc_cyc.size() ? acc_cyc[acc_cyc.size()-1] - acc_cyc[0] : -1);
      end
   endtask

   task automatic test_stall();
      bq_t p;
      int idx, low;
      bit held_ok;
      logic [WW-1:0] g0, g1;
      clear_log();
      for (int i = 0; i < 16; i++) p.push_back(8'($urandom));
      model_pkt(p);
      idx     = 0;
      low     = 0;
      held_ok = 1'b1;
      for (int c = 0; c < 40; c++) begin
         full_man      = (c >= 8 && c < 13);
         bus.s_valid_i = (idx < 16);
         bus.s_data_i  = idx < 16 ? p[idx] : 8'h00;
         bus.s_last_i  = (idx == 15);
         @(negedge clk);
         if (bus.s_valid_i && bus.s_ready_o !== 1'b1) low++;
         if (full_man && bus.fifo_data_o !== exp_w[0]) held_ok = 1'b0;
         if (bus.s_valid_i && bus.s_ready_o === 1'b1) idx++;
         @(posedge clk);
         #1;
      end
      full_man = 1'b0;
      idle(3);
      g0 = wr_q.size() > 0 ? wr_q[0] : 'x;
      g1 = wr_q.size() > 1 ? wr_q[1] : 'x;
      n_checks++;
      if (low != 5) begin
         n_fail++;
         $display("FAIL stall_ready_low: got %0d cycles want 5", low);
      end
      n_checks++;
      if (!held_ok) begin
         n_fail++;
         $display("FAIL stall_hold: data moved, want %h held", exp_w[0]);
      end
      n_checks++;
      if (wr_q.size() != 2 || idx != 16) begin
         n_fail++;
         $display("FAIL stall_count: got %0d writes %0d bytes want 2/16",
                  wr_q.size(), idx);
      end
      n_checks++;
      if (g0 !== exp_w[0] || g1 !== exp_w[1]) begin
         n_fail++;
         $display("FAIL stall_data: got %h %h want %h %h",
                  g0, g1, exp_w[0], exp_w[1]);
      end
   endtask

   task automatic test_reset_mid();
      logic [WW-1:0] got;
      int gl;
      clear_log();
      for (int i = 0; i < 5; i++) put_byte(8'(8'h90 + i), 1'b0, 0);
      bus.s_valid_i = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(3);
      n_checks++;
      if (wr_q.size() != 0 || len_q.size() != 0) begin
         n_fail++;
         $display("FAIL midrst_discard: got %0d writes %0d lens want 0/0",
                  wr_q.size(), len_q.size());
      end
      put_byte(8'h11, 1'b1, 0);
      idle(4);
      got = wr_q.size() > 0 ? wr_q[0] : 'x;
      gl  = len_q.size() > 0 ? len_q[0] : 0;
      n_checks++;
      if (wr_q.size() != 1 || got !== 64'h11) begin
         n_fail++;
         $display("FAIL midrst_next: got %0d writes %h want 1 x 11",
                  wr_q.size(), got);
      end
      n_checks++;
      if (gl != (LEN_ON ? 1 : 0)) begin
         n_fail++;
         $display("FAIL midrst_len: got %0d want %0d", gl, LEN_ON ? 1 : 0);
      end
   endtask

   task automatic test_random();
      bq_t p;
      logic [WW-1:0] got;
      int n;
      clear_log();
      rnd_mode = 1'b1;
      for (int k = 0; k < 40; k++) begin
         p.delete();
         n = $urandom_range(1, 20);
         for (int i = 0; i < n; i++) p.push_back(8'($urandom));
         send_pkt(p, 30);
      end
      bus.s_valid_i = 1'b0;
      rnd_mode = 1'b0;
      idle(5);
      n_checks++;
      if (wr_q.size() != exp_w.size()) begin
         n_fail++;
         $display("FAIL rand_count: got %0d want %0d",
                  wr_q.size(), exp_w.size());
      end
      for (int i = 0; i < exp_w.size(); i++) begin
         got = i < wr_q.size() ? wr_q[i] : 'x;
         n_checks++;
         if (got !== exp_w[i]) begin
            n_fail++;
            $display("FAIL rand_word[%0d]: got %h want %h", i, got, exp_w[i]);
         end
      end
      n_checks++;
      if (len_q.size() != (LEN_ON ? exp_len.size() : 0)) begin
         n_fail++;
         $display("FAIL rand_len_count: got %0d want %0d", len_q.size(),
                  LEN_ON ? exp_len.size() : 0);
      end
      for (int i = 0; i < len_q.size(); i++) begin
         n_checks++;
         if (i >= exp_len.size() || len_q[i] != exp_len[i]) begin
            n_fail++;
            $display("FAIL rand_len[%0d]: got %0d want %0d", i, len_q[i],
                     i < exp_len.size() ? exp_len[i] : -1);
         end
      end
   endtask

   task automatic test_saturation();
      localparam int N = 70000;
      logic [WW-1:0] want, got;
      int gl;
      clear_log();
      for (int i = 0; i < N; i++) put_byte(8'(i % 256), i == N - 1, 0);
      idle(4);
      want = '0;
      for (int k = 0; k < 8; k++) want[8*k +: 8] = 8'((N - 8 + k) % 256);
      got = wr_q.size() > 0 ? wr_q[wr_q.size()-1] : 'x;
      gl  = len_q.size() > 0 ? len_q[0] : 0;
      n_checks++;
      if (wr_q.size() != (N + 7) / 8) begin
         n_fail++;
         $display("FAIL sat_words: got %0d want %0d", wr_q.size(), (N + 7) / 8);
      end
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL sat_last_word: got %h want %h", got, want);
      end
      n_checks++;
      if (gl != (LEN_ON ? 65535 : 0)) begin
         n_fail++;
         $display("FAIL sat_len: got %0d want %0d", gl, LEN_ON ? 65535 : 0);
      end
   endtask

   initial begin
      bus.s_valid_i = 1'b0;
      bus.s_data_i  = 8'h00;
      bus.s_last_i  = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_full_word();
      test_partial();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      test_random();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
